pipelined_adder_subtractor: RTL and testbench

//  Parametrised, pipelined successor of the 4-bit ripple adder/subtractor.

---
 rtl/pipelined_adder_subtractor.sv | 113 +++++++++++
 tb/tb_pipelined_adder_subtractor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_subtractor.sv
// rtl/pipelined_adder_subtractor.sv - pipelined WIDTH-bit adder/subtractor with valid/ready handshake and flags
module pipelined_adder_subtractor #(
    parameter int WIDTH   = 8,
    parameter int STAGE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sd,
    output logic             cbout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / STAGE_W;

    // The whole pipeline moves as one: it advances unless a valid result is being held.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage k adds slice k. Each stage keeps only the operand bits later stages still need,
    // plus the low sum bits computed so far (skew). The last stage register is the output.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * STAGE_W;
        localparam int HI = LO + STAGE_W;

        logic [WIDTH-1:LO]  src_a;
        logic [WIDTH-1:LO]  src_bx;
        logic               src_c;
        logic               src_v;
        logic [STAGE_W:0]   slice;
        logic [HI-1:0]      sum_d;
        logic [HI-1:0]      sum_q;
        logic               c_q;
        logic               v_q;

        assign slice = {1'b0, src_a[HI-1:LO]} + {1'b0, src_bx[HI-1:LO]}
                     + {{STAGE_W{1'b0}}, src_c};

        if (k == 0) begin : g_src
            // Subtraction is a + ~b + 1: invert b here, feed sub in as the carry.
            assign src_a  = a;
            assign src_bx = b ^ {WIDTH{sub}};
            assign src_c  = sub;
            assign src_v  = in_valid;
            assign sum_d  = slice[STAGE_W-1:0];
        end else begin : g_src
            assign src_a  = g_stage[k-1].g_keep.a_q;
            assign src_bx = g_stage[k-1].g_keep.bx_q;
            assign src_c  = g_stage[k-1].c_q;
            assign src_v  = g_stage[k-1].v_q;
            assign sum_d  = {slice[STAGE_W-1:0], g_stage[k-1].sum_q};
        end

        // Stage valid, partial sum and slice carry; frozen while the output is stalled.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (adv) begin
                v_q   <= src_v;
                sum_q <= sum_d;
                c_q   <= slice[STAGE_W];
            end
        end

        if (k < STAGES - 1) begin : g_keep
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] bx_q;

            // Operand slices not yet consumed travel down with the transaction.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q  <= '0;
                    bx_q <= '0;
                end else if (adv) begin
                    a_q  <= src_a[WIDTH-1:HI];
                    bx_q <= src_bx[WIDTH-1:HI];
                end
            end
        end else begin : g_flags
            logic ovf_q;
            logic zero_q;

            // Flags come from the complete sum and are registered alongside it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= (src_a[WIDTH-1] == src_bx[WIDTH-1])
                           && (sum_d[WIDTH-1] != src_a[WIDTH-1]);
                    zero_q <= ~|sum_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sd        = g_stage[STAGES-1].sum_q;
    assign cbout     = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_flags.ovf_q;
    assign zero      = g_stage[STAGES-1].g_flags.zero_q;

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// tb/tb_pipelined_adder_subtractor.sv - directed and random checks for pipelined_adder_subtractor
module tb_pipelined_adder_subtractor;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sd;
        logic       cb;
        logic       ov;
        logic       z;
    } vec_t;

    typedef struct {
        logic [31:0] sd;
        logic        cb;
        logic        ov;
        logic        z;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rsub;
    logic        rand_on;

    logic [3:0]  in_ready_v;
    logic [3:0]  out_valid_v;
    logic [3:0]  cbout_v;
    logic [3:0]  ovf_v;
    logic [3:0]  zero_v;
    logic [31:0] sd_v [4];
    int          pending [4];

    int n_total;
    int n_pass;

    vec_t vecs [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint m, half, ua, ub, u, sa, sb, r;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        if (s) begin
            u    = ua - ub;
            e.cb = (ua >= ub);
        end else begin
            u    = ua + ub;
            e.cb = (u > m);
        end
        e.sd = 32'(u & m);
        e.z  = ((u & m) == 0);
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        r    = s ? sa - sb : sa + sb;
        e.ov = (r >= half) || (r < -half);
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [10:0] res0();
        return {sd_v[0][7:0], cbout_v[0], ovf_v[0], zero_v[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Four configurations: 8/4 (directed + random), 8/8, 16/4, 32/8 (random).
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 3) ? 32 : (g == 2) ? 16 : 8;
        localparam int S = (g == 0 || g == 2) ? 4 : 8;

        logic [W-1:0] sd_l;
        exp_t         q [$];

        pipelined_adder_subtractor #(.WIDTH(W), .STAGE_W(S)) dut (
            .clk(clk),
            .rst(rst),
            .in_valid(in_valid),
            .in_ready(in_ready_v[g]),
            .a(ra[W-1:0]),
            .b(rb[W-1:0]),
            .sub(rsub),
            .out_valid(out_valid_v[g]),
            .out_ready(out_ready),
            .sd(sd_l),
            .cbout(cbout_v[g]),
            .ovf(ovf_v[g]),
            .zero(zero_v[g])
        );

        assign sd_v[g] = 32'(sd_l);

        // Scoreboard: transfers are decided by the values seen mid-cycle.
        always @(negedge clk) begin
            exp_t e;
            if (rand_on) begin
                if (out_valid_v[g] && out_ready) begin
                    if (q.size() == 0) begin
                        check($sformatf("rand_extra_w%0d_s%0d", W, S), 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        pending[g]--;
                        check($sformatf("rand_w%0d_s%0d", W, S),
                              {sd_v[g], cbout_v[g], ovf_v[g], zero_v[g]}, {e.sd, e.cb, e.ov, e.z});
                    end
                end
                if (in_valid && in_ready_v[g]) begin
                    q.push_back(model(W, ra, rb, rsub));
                    pending[g]++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int got;
        int ghosts;

        n_total = 0;
        n_pass  = 0;
        for (int i = 0; i < 4; i++) pending[i] = 0;

        vecs[0] = '{8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h55, 8'h3C, 1'b1, 8'h19, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 8'h55, 1'b1, 8'hE7, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ra        = '0;
        rb        = '0;
        rsub      = 1'b0;
        rand_on   = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        check("reset_out_valid", out_valid_v[0], 1'b0);
        check("reset_fields", res0(), 11'd0);
        check("reset_in_ready", in_ready_v[0], 1'b1);

        // Single operations: invisible after one edge, present after two.
        for (int i = 0; i < 8; i++) begin
            ra       = 32'(vecs[i].a);
            rb       = 32'(vecs[i].b);
            rsub     = vecs[i].sub;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_early", i), out_valid_v[0], 1'b0);
            step();
            check($sformatf("vec%0d_valid", i), out_valid_v[0], 1'b1);
            check($sformatf("vec%0d_result", i), res0(),
                  {vecs[i].sd, vecs[i].cb, vecs[i].ov, vecs[i].z});
        end
        step();

        // Backpressure: four back-to-back ops, output stalled in cycles 3..5.
        sent = 0;
        got  = 0;
        for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 3 && c < 6);
            in_valid  = (sent < 4);
            if (sent < 4) begin
                ra   = 32'(vecs[sent].a);
                rb   = 32'(vecs[sent].b);
                rsub = vecs[sent].sub;
            end
            #4;
            if (!out_ready) begin
                check($sformatf("bp_in_ready_c%0d", c), in_ready_v[0], 1'b0);
                check($sformatf("bp_sd_hold_c%0d", c), sd_v[0][7:0], vecs[1].sd);
            end
            if (in_valid && in_ready_v[0]) sent++;
            if (out_valid_v[0] && out_ready) begin
                if (got < 4)
                    check($sformatf("bp_result%0d", got), res0(),
                          {vecs[got].sd, vecs[got].cb, vecs[got].ov, vecs[got].z});
                got++;
            end
            step();
        end
        check("bp_count", 64'(got), 64'd4);

        // Reset with two operations in flight and the output stalled.
        out_ready = 1'b1;
        ra = 32'(vecs[0].a); rb = 32'(vecs[0].b); rsub = vecs[0].sub; in_valid = 1'b1;
        step();
        ra = 32'(vecs[1].a); rb = 32'(vecs[1].b); rsub = vecs[1].sub;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        check("rst_out_valid", out_valid_v[0], 1'b0);
        check("rst_sd", sd_v[0][7:0], 8'h00);
        check("rst_in_ready", in_ready_v[0], 1'b1);
        ghosts = 0;
        for (int c = 0; c < 4; c++) begin
            #4;
            if (out_valid_v[0]) ghosts++;
            step();
        end
        check("rst_no_ghosts", 64'(ghosts), 64'd0);
        ra = 32'(vecs[4].a); rb = 32'(vecs[4].b); rsub = vecs[4].sub; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("rst_new_early", out_valid_v[0], 1'b0);
        step();
        check("rst_new_valid", out_valid_v[0], 1'b1);
        check("rst_new_result", res0(), {vecs[4].sd, vecs[4].cb, vecs[4].ov, vecs[4].z});

        // Random traffic on all configurations, starting from empty pipelines.
        rst = 1'b1;
        step();
        rst     = 1'b0;
        rand_on = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ra        = pick();
            rb        = pick();
            rsub      = 1'($urandom_range(0, 1));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) step();
        for (int i = 0; i < 4; i++)
            check($sformatf("drain_dut%0d", i), 64'(pending[i]), 64'd0);
        rand_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
